// File: rtl/tcd1290d_pkg.sv
// Shared constants and types for the TCD1290D receive path.
//   Holds the default geometry, the optical-black window, the delay and line-counter
//   widths, the capture FSM state enum, and a helper that sizes the pixel index.
package tcd1290d_pkg;

  localparam int unsigned TCD1290D_DATA_WIDTH  = 12;
  localparam int unsigned TCD1290D_ACTIVE_PIX  = 3000;
  localparam int unsigned TCD1290D_DUMMY_FRONT = 32;
  localparam int unsigned TCD1290D_OB_START    = 12;
  localparam int unsigned TCD1290D_OB_LOG2     = 4;
  localparam int unsigned TCD1290D_DLY_W       = 8;
  localparam int unsigned TCD1290D_LINE_CNT_W  = 16;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_LINE = 1'b1
  } cap_state_e;

  // Index width able to hold 0..line_pix inclusive; the index saturates at line_pix.
  function automatic int unsigned idx_width(input int unsigned line_pix);
    return $clog2(line_pix + 1);
  endfunction

endpackage

// File: rtl/tcd1290d_capture_if.sv
// AXI4-Stream pixel channel from the CCD capture block to image processing.
//   tdata  : pixel value
//   tvalid : pixel valid
//   tready : downstream ready
//   tuser  : first active pixel of the line
//   tlast  : last active pixel of the line
//   master : capture side (drives data); slave : consumer side (drives tready)
interface tcd1290d_capture_if
  import tcd1290d_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = TCD1290D_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/ccd_ob_clamp.sv
// Optical-black estimation and black-clamp stage.
//   Sums the captured OB pixels of a line, publishes their average as ob_level one cycle
//   after the last OB sample, and registers active pixels (stage 1) optionally with
//   ob_level subtracted and floored at zero.
//   clk, rst_n   : clock, asynchronous active-low reset
//   line_start   : a new line begins, clears the OB accumulator
//   cap_valid    : an ADC sample is captured this cycle, with its index and data
//   clamp_en     : subtract ob_level from active pixels
//   st1_*        : stage-1 registered pixel with first/last markers
//   ob_level     : OB average of the current/last line
module ccd_ob_clamp
  import tcd1290d_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = TCD1290D_DATA_WIDTH,
  parameter int unsigned ACTIVE_PIX  = TCD1290D_ACTIVE_PIX,
  parameter int unsigned DUMMY_FRONT = TCD1290D_DUMMY_FRONT,
  parameter int unsigned OB_START    = TCD1290D_OB_START,
  parameter int unsigned OB_LOG2     = TCD1290D_OB_LOG2,
  parameter int unsigned IDX_W       = idx_width(DUMMY_FRONT + ACTIVE_PIX)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_start,
  input  logic                  cap_valid,
  input  logic [IDX_W-1:0]      cap_idx,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  clamp_en,
  output logic                  st1_valid,
  output logic [DATA_WIDTH-1:0] st1_data,
  output logic                  st1_user,
  output logic                  st1_last,
  output logic [DATA_WIDTH-1:0] ob_level
);

  localparam int unsigned SUM_W   = DATA_WIDTH + OB_LOG2;
  localparam int unsigned OB_LAST = OB_START + (1 << OB_LOG2) - 1;
  localparam int unsigned ACT_END = DUMMY_FRONT + ACTIVE_PIX;

  logic [SUM_W-1:0]      ob_sum;
  logic                  ob_done;
  logic                  in_ob_c;
  logic                  in_act_c;
  logic [DATA_WIDTH-1:0] pix_c;

  // Window decode and clamp arithmetic for the sample captured this cycle.
  always_comb begin
    in_ob_c  = cap_valid && (cap_idx >= IDX_W'(OB_START)) && (cap_idx <= IDX_W'(OB_LAST));
    in_act_c = cap_valid && (cap_idx >= IDX_W'(DUMMY_FRONT)) && (cap_idx < IDX_W'(ACT_END));
    pix_c    = cap_data;
    if (clamp_en) begin
      pix_c = (cap_data > ob_level) ? (cap_data - ob_level) : '0;
    end
  end

  // OB accumulator; 2**OB_LOG2 samples of DATA_WIDTH bits cannot overflow SUM_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_sum   <= '0;
      ob_done  <= 1'b0;
      ob_level <= '0;
    end else begin
      ob_done <= 1'b0;
      if (line_start) begin
        ob_sum <= '0;
      end else if (in_ob_c) begin
        ob_sum  <= ob_sum + SUM_W'(cap_data);
        ob_done <= (cap_idx == IDX_W'(OB_LAST));
      end
      if (ob_done) begin
        ob_level <= DATA_WIDTH'(ob_sum >> OB_LOG2);
      end
    end
  end

  // Stage 1: active pixel register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st1_valid <= 1'b0;
      st1_data  <= '0;
      st1_user  <= 1'b0;
      st1_last  <= 1'b0;
    end else begin
      st1_valid <= in_act_c;
      if (in_act_c) begin
        st1_data <= pix_c;
        st1_user <= (cap_idx == IDX_W'(DUMMY_FRONT));
        st1_last <= (cap_idx == IDX_W'(ACT_END - 1));
      end
    end
  end

endmodule

// File: rtl/tcd1290d_capture.sv
// Receive side of the TCD1290D linear-CCD interface.
//   Detects SH/RS edges from the driver, samples the ADC a programmable delay after each
//   RS fall, drops dummy pixels, estimates the OB level and streams active pixels.
//   sys_clk, resetn : clock, asynchronous active-low reset
//   sh, rs, cp      : driver strobes (SH rise = new line, RS fall = pixel, CP high = no sample)
//   adc_data        : ADC output, valid at the sample point
//   sample_dly      : cycles from RS fall to ADC capture
//   clamp_en        : subtract ob_level from active pixels
//   m_axis          : AXI4-Stream pixel output (master)
//   ob_level        : OB average
//   line_cnt        : completed lines
//   line_busy       : a line is being received
//   overflow        : sticky, a pixel was dropped because the output register was full
//   short_line      : sticky, SH rose before the line was complete
module tcd1290d_capture
  import tcd1290d_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = TCD1290D_DATA_WIDTH,
  parameter int unsigned ACTIVE_PIX  = TCD1290D_ACTIVE_PIX,
  parameter int unsigned DUMMY_FRONT = TCD1290D_DUMMY_FRONT,
  parameter int unsigned OB_START    = TCD1290D_OB_START,
  parameter int unsigned OB_LOG2     = TCD1290D_OB_LOG2
) (
  input  logic                           sys_clk,
  input  logic                           resetn,
  input  logic                           sh,
  input  logic                           rs,
  input  logic                           cp,
  input  logic [DATA_WIDTH-1:0]          adc_data,
  input  logic [TCD1290D_DLY_W-1:0]      sample_dly,
  input  logic                           clamp_en,
  tcd1290d_capture_if.master             m_axis,
  output logic [DATA_WIDTH-1:0]          ob_level,
  output logic [TCD1290D_LINE_CNT_W-1:0] line_cnt,
  output logic                           line_busy,
  output logic                           overflow,
  output logic                           short_line
);

  localparam int unsigned LINE_PIX = DUMMY_FRONT + ACTIVE_PIX;
  localparam int unsigned IDX_W    = idx_width(LINE_PIX);
  localparam int unsigned DLY_W    = TCD1290D_DLY_W;
  localparam int unsigned LCNT_W   = TCD1290D_LINE_CNT_W;

  cap_state_e            state;
  logic                  sh_d;
  logic                  rs_d;
  logic [IDX_W-1:0]      pix_idx;
  logic [IDX_W-1:0]      samp_idx;
  logic [DLY_W-1:0]      dly_cnt;
  logic                  pending;

  logic                  sh_rise_c;
  logic                  rs_fall_c;
  logic                  line_end_c;
  logic                  cap_fire_c;
  logic                  cap_valid_c;
  logic [IDX_W-1:0]      cap_idx_c;

  logic                  st1_valid;
  logic [DATA_WIDTH-1:0] st1_data;
  logic                  st1_user;
  logic                  st1_last;

  logic                  tvalid_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tuser_q;
  logic                  tlast_q;

  assign sh_rise_c  = sh & ~sh_d;
  assign rs_fall_c  = ~rs & rs_d;
  // The line only ends once the last pixel's delayed sample has been taken.
  assign line_end_c = (state == CAP_LINE) && (pix_idx == IDX_W'(LINE_PIX)) && !pending;

  // Capture strobe: immediately on RS fall for zero delay, else when the delay expires.
  // A new RS fall aborts a pending sample, so the expiry path is masked by rs_fall_c.
  always_comb begin
    cap_fire_c = 1'b0;
    cap_idx_c  = samp_idx;
    if ((state == CAP_LINE) && !sh_rise_c && !line_end_c) begin
      if (rs_fall_c) begin
        if (sample_dly == '0) begin
          cap_fire_c = 1'b1;
          cap_idx_c  = pix_idx;
        end
      end else if (pending && (dly_cnt == '0)) begin
        cap_fire_c = 1'b1;
      end
    end
    cap_valid_c = cap_fire_c & ~cp;
  end

  // Edge registers, line FSM, pixel index and sample delay counter.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      sh_d       <= 1'b0;
      rs_d       <= 1'b0;
      state      <= CAP_IDLE;
      line_busy  <= 1'b0;
      pix_idx    <= '0;
      samp_idx   <= '0;
      dly_cnt    <= '0;
      pending    <= 1'b0;
      line_cnt   <= '0;
      short_line <= 1'b0;
    end else begin
      sh_d <= sh;
      rs_d <= rs;
      case (state)
        CAP_IDLE: begin
          if (sh_rise_c) begin
            state     <= CAP_LINE;
            line_busy <= 1'b1;
            pix_idx   <= '0;
            pending   <= 1'b0;
          end
        end
        CAP_LINE: begin
          if (sh_rise_c) begin
            if (pix_idx < IDX_W'(LINE_PIX)) begin
              short_line <= 1'b1;
            end
            pix_idx <= '0;
            pending <= 1'b0;
          end else if (line_end_c) begin
            state     <= CAP_IDLE;
            line_busy <= 1'b0;
            line_cnt  <= line_cnt + LCNT_W'(1);
          end else if (rs_fall_c) begin
            samp_idx <= pix_idx;
            if (pix_idx != IDX_W'(LINE_PIX)) begin
              pix_idx <= pix_idx + IDX_W'(1);
            end
            pending <= (sample_dly != '0);
            dly_cnt <= sample_dly - DLY_W'(1);
          end else if (pending) begin
            if (dly_cnt == '0) begin
              pending <= 1'b0;
            end else begin
              dly_cnt <= dly_cnt - DLY_W'(1);
            end
          end
        end
        default: begin
          state     <= CAP_IDLE;
          line_busy <= 1'b0;
        end
      endcase
    end
  end

  ccd_ob_clamp #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ACTIVE_PIX  (ACTIVE_PIX),
    .DUMMY_FRONT (DUMMY_FRONT),
    .OB_START    (OB_START),
    .OB_LOG2     (OB_LOG2),
    .IDX_W       (IDX_W)
  ) u_ob_clamp (
    .clk        (sys_clk),
    .rst_n      (resetn),
    .line_start (sh_rise_c),
    .cap_valid  (cap_valid_c),
    .cap_idx    (cap_idx_c),
    .cap_data   (adc_data),
    .clamp_en   (clamp_en),
    .st1_valid  (st1_valid),
    .st1_data   (st1_data),
    .st1_user   (st1_user),
    .st1_last   (st1_last),
    .ob_level   (ob_level)
  );

  // Stage 2: single AXIS output register; a pixel arriving while it is stalled is dropped.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      overflow <= 1'b0;
    end else if (st1_valid) begin
      if (tvalid_q && !m_axis.tready) begin
        overflow <= 1'b1;
      end else begin
        tvalid_q <= 1'b1;
        tdata_q  <= st1_data;
        tuser_q  <= st1_user;
        tlast_q  <= st1_last;
      end
    end else if (m_axis.tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tuser  = tuser_q;
  assign m_axis.tlast  = tlast_q;

endmodule
